multicycle_control: RTL and testbench

//  Multi-cycle main control FSM for the RV64 datapath. Sequences each instruction through

---
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle main controller and the RV64 datapath/memory port.
// master = controller side, slave = datapath side.
interface multicycle_control_if #(
   parameter int unsigned COUNT_W = 32
);
   logic [6:0]         op_code;
   logic               mem_ready;
   logic               pc_write;
   logic               pc_write_cond;
   logic               ir_write;
   logic               i_or_d;
   logic               mem_read;
   logic               mem_write;
   logic [1:0]         mem_to_reg;
   logic               reg_write;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [1:0]         alu_op;
   logic [1:0]         pc_source;
   logic               illegal_op;
   logic [3:0]         state_o;
   logic [COUNT_W-1:0] instr_count;

   modport master (
      input  op_code, mem_ready,
      output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
             mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
             illegal_op, state_o, instr_count
   );

   modport slave (
      output op_code, mem_ready,
      input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
             mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
             illegal_op, state_o, instr_count
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the RV64 datapath: fetch/decode/execute/memory/writeback
// sequencing, memory-ready handshake, sticky illegal-opcode flag and retired-instruction count.
module multicycle_control #(
   parameter bit          ENABLE_IMM = 1'b1,
   parameter bit          ENABLE_JAL = 1'b1,
   parameter int unsigned COUNT_W    = 32
) (
   input logic                  clk,
   input logic                  rst,
   multicycle_control_if.master bus
);
   localparam int unsigned STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MADDR  = 4'd2,
      S_MRD    = 4'd3,
      S_MWB    = 4'd4,
      S_MWR    = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_TRAP   = 4'd15
   } state_e;

   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef struct packed {
      logic       fetch;
      logic       mem_read;
      logic       mem_write;
      logic       i_or_d;
      logic       pc_write;
      logic       pc_write_cond;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] mem_to_reg;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   // Moore output table; ir_write/pc_write in FETCH are added later from mem_ready.
   function automatic ctrl_t decode_ctrl(input state_e s, input logic is_imm);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.fetch     = 1'b1;
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         S_DECODE: c.alu_src_b = 2'b11;
         S_MADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MRD: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         S_MWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 2'b01;
         end
         S_MWR: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         S_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = is_imm ? 2'b10 : 2'b00;
            c.alu_op    = is_imm ? 2'b11 : 2'b10;
         end
         S_RWB: c.reg_write = 1'b1;
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = 2'b01;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
         end
         S_JUMP: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 2'b10;
            c.pc_write   = 1'b1;
            c.pc_source  = 2'b10;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_e             state_q, state_d;
   ctrl_t              ctrl_q, ctrl_d;
   logic               is_store_q, is_store_d;
   logic               is_imm_q, is_imm_d;
   logic               illegal_q, illegal_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               retire_c;

   // Next state, opcode-class latch, retire counting and next-cycle control decode.
   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      is_imm_d   = is_imm_q;
      case (state_q)
         S_FETCH: if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            is_store_d = (bus.op_code == OP_SD);
            is_imm_d   = (bus.op_code == OP_IMM);
            case (bus.op_code)
               OP_LD, OP_SD: state_d = S_MADDR;
               OP_R:         state_d = S_EXEC;
               OP_IMM:       state_d = ENABLE_IMM ? S_EXEC : S_TRAP;
               OP_BEQ:       state_d = S_BRANCH;
               OP_JAL:       state_d = ENABLE_JAL ? S_JUMP : S_TRAP;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MADDR:  state_d = is_store_q ? S_MWR : S_MRD;
         S_MRD:    if (bus.mem_ready) state_d = S_MWB;
         S_MWB:    state_d = S_FETCH;
         S_MWR:    if (bus.mem_ready) state_d = S_FETCH;
         S_EXEC:   state_d = S_RWB;
         S_RWB:    state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_TRAP;
      endcase

      retire_c  = (state_q != S_FETCH) && (state_d == S_FETCH);
      count_d   = retire_c ? count_q + COUNT_W'(1) : count_q;
      illegal_d = illegal_q | (state_d == S_TRAP);
      ctrl_d    = decode_ctrl(state_d, is_imm_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         ctrl_q     <= decode_ctrl(S_FETCH, 1'b0);
         is_store_q <= 1'b0;
         is_imm_q   <= 1'b0;
         illegal_q  <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         is_store_q <= is_store_d;
         is_imm_q   <= is_imm_d;
         illegal_q  <= illegal_d;
         count_q    <= count_d;
      end
   end

   // Strobes are forced low during the reset cycle; fetch completion follows mem_ready.
   logic fetch_done_c;
   assign fetch_done_c = ctrl_q.fetch & bus.mem_ready & ~rst;

   assign bus.mem_read      = ctrl_q.mem_read & ~rst;
   assign bus.mem_write     = ctrl_q.mem_write & ~rst;
   assign bus.ir_write      = fetch_done_c;
   assign bus.pc_write      = (ctrl_q.pc_write & ~rst) | fetch_done_c;
   assign bus.pc_write_cond = ctrl_q.pc_write_cond & ~rst;
   assign bus.reg_write     = ctrl_q.reg_write & ~rst;
   assign bus.i_or_d        = ctrl_q.i_or_d;
   assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
   assign bus.alu_src_a     = ctrl_q.alu_src_a;
   assign bus.alu_src_b     = ctrl_q.alu_src_b;
   assign bus.alu_op        = ctrl_q.alu_op;
   assign bus.pc_source     = ctrl_q.pc_source;
   assign bus.illegal_op    = illegal_q;
   assign bus.state_o       = state_q;
   assign bus.instr_count   = count_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected outputs are queued per instruction and
// compared as the DUT steps; a second instance covers disabled opcodes and counter wrap.
module tb_multicycle_control;
   localparam logic [3:0] ST_F = 4'd0,  ST_D = 4'd1, ST_MA = 4'd2, ST_MRD = 4'd3, ST_MWB = 4'd4;
   localparam logic [3:0] ST_MWR = 4'd5, ST_EX = 4'd6, ST_RWB = 4'd7, ST_BR = 4'd8, ST_J = 4'd9;
   localparam logic [3:0] ST_TRAP = 4'd15;
   localparam logic [6:0] OP_LD = 7'b0000011, OP_SD = 7'b0100011, OP_R = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;

   typedef struct packed {
      logic [3:0] st;
      logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, reg_write;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b, alu_op, pc_source;
      logic       illegal;
   } out_t;

   typedef struct packed {
      logic        rdy;
      logic [6:0]  op;
      out_t        exp;
      logic [31:0] cnt;
   } step_t;

   logic clk, rst_a, rst_b;
   multicycle_control_if #(.COUNT_W(32)) ifa ();
   multicycle_control_if #(.COUNT_W(4))  ifb ();

   multicycle_control #(.ENABLE_IMM(1'b1), .ENABLE_JAL(1'b1), .COUNT_W(32)) u_dut_a (
      .clk(clk), .rst(rst_a), .bus(ifa.master));
   multicycle_control #(.ENABLE_IMM(1'b0), .ENABLE_JAL(1'b0), .COUNT_W(4)) u_dut_b (
      .clk(clk), .rst(rst_b), .bus(ifb.master));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   out_t        obs_a, obs_b;
   logic [31:0] cnt_a, cnt_b;
   assign obs_a = {ifa.state_o, ifa.mem_read, ifa.mem_write, ifa.i_or_d, ifa.ir_write, ifa.pc_write,
                   ifa.pc_write_cond, ifa.reg_write, ifa.mem_to_reg, ifa.alu_src_a, ifa.alu_src_b,
                   ifa.alu_op, ifa.pc_source, ifa.illegal_op};
   assign obs_b = {ifb.state_o, ifb.mem_read, ifb.mem_write, ifb.i_or_d, ifb.ir_write, ifb.pc_write,
                   ifb.pc_write_cond, ifb.reg_write, ifb.mem_to_reg, ifb.alu_src_a, ifb.alu_src_b,
                   ifb.alu_op, ifb.pc_source, ifb.illegal_op};
   assign cnt_a = ifa.instr_count;
   assign cnt_b = 32'(ifb.instr_count);

   int          n_checks, n_fail;
   logic [31:0] exp_cnt;
   step_t       sb_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Expected outputs per state, straight from the state-output table.
   function automatic out_t exp_out(input logic [3:0] st, input logic rdy, input logic imm);
      out_t o;
      o    = '0;
      o.st = st;
      case (st)
         ST_F:   begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
         ST_D:   o.alu_src_b = 2'b11;
         ST_MA:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
         ST_MRD: begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
         ST_MWB: begin o.reg_write = 1'b1; o.mem_to_reg = 2'b01; end
         ST_MWR: begin o.mem_write = 1'b1; o.i_or_d = 1'b1; end
         ST_EX:  begin
            o.alu_src_a = 1'b1;
            o.alu_src_b = imm ? 2'b10 : 2'b00;
            o.alu_op    = imm ? 2'b11 : 2'b10;
         end
         ST_RWB: o.reg_write = 1'b1;
         ST_BR:  begin o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1; o.pc_source = 2'b01; end
         ST_J:   begin o.reg_write = 1'b1; o.mem_to_reg = 2'b10; o.pc_write = 1'b1; o.pc_source = 2'b10; end
         ST_TRAP: o.illegal = 1'b1;
         default: o = '0;
      endcase
      return o;
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push_step(input logic [3:0] st, input logic rdy, input logic [6:0] op, input logic imm);
      step_t s;
      s.rdy = rdy;
      s.op  = op;
      s.exp = exp_out(st, rdy, imm);
      s.cnt = exp_cnt;
      sb_q.push_back(s);
   endtask

   // Queue the full cycle-by-cycle trace of one instruction, including memory waits.
   task automatic push_instr(input logic [6:0] op, input int fw, input int mw, input bit imm_en,
                             input bit jal_en, input logic [31:0] cmask);
      bit trap;
      trap = 1'b0;
      for (int i = 0; i < fw; i++) push_step(ST_F, 1'b0, 7'($urandom), 1'b0);
      push_step(ST_F, 1'b1, 7'($urandom), 1'b0);
      push_step(ST_D, rnd_bit(), op, 1'b0);
      case (op)
         OP_LD: begin
            push_step(ST_MA, rnd_bit(), 7'($urandom), 1'b0);
            for (int i = 0; i < mw; i++) push_step(ST_MRD, 1'b0, 7'($urandom), 1'b0);
            push_step(ST_MRD, 1'b1, 7'($urandom), 1'b0);
            push_step(ST_MWB, rnd_bit(), 7'($urandom), 1'b0);
         end
         OP_SD: begin
            push_step(ST_MA, rnd_bit(), 7'($urandom), 1'b0);
            for (int i = 0; i < mw; i++) push_step(ST_MWR, 1'b0, 7'($urandom), 1'b0);
            push_step(ST_MWR, 1'b1, 7'($urandom), 1'b0);
         end
         OP_R: begin
            push_step(ST_EX, rnd_bit(), 7'($urandom), 1'b0);
            push_step(ST_RWB, rnd_bit(), 7'($urandom), 1'b0);
         end
         OP_IMM: begin
            if (imm_en) begin
               push_step(ST_EX, rnd_bit(), 7'($urandom), 1'b1);
               push_step(ST_RWB, rnd_bit(), 7'($urandom), 1'b0);
            end else trap = 1'b1;
         end
         OP_BEQ: push_step(ST_BR, rnd_bit(), 7'($urandom), 1'b0);
         OP_JAL: begin
            if (jal_en) push_step(ST_J, rnd_bit(), 7'($urandom), 1'b0);
            else trap = 1'b1;
         end
         default: trap = 1'b1;
      endcase
      if (trap) begin
         for (int i = 0; i < 20; i++) push_step(ST_TRAP, rnd_bit(), 7'($urandom), 1'b0);
      end else begin
         exp_cnt = (exp_cnt + 32'd1) & cmask;
      end
   endtask

   task automatic drive(input int d, input logic rdy, input logic [6:0] op);
      if (d == 0) begin ifa.mem_ready = rdy; ifa.op_code = op; end
      else begin ifb.mem_ready = rdy; ifb.op_code = op; end
   endtask

   task automatic set_rst(input int d, input logic v);
      if (d == 0) rst_a = v;
      else rst_b = v;
   endtask

   function automatic logic [31:0] strobes(input out_t o);
      return 32'({o.mem_read, o.mem_write, o.ir_write, o.pc_write, o.pc_write_cond, o.reg_write});
   endfunction

   // Drain the scoreboard: drive after the rising edge, compare on the falling edge.
   task automatic run_sb(input int d);
      step_t s;
      out_t  o;
      while (sb_q.size() > 0) begin
         s = sb_q.pop_front();
         drive(d, s.rdy, s.op);
         @(negedge clk);
         o = (d == 0) ? obs_a : obs_b;
         check($sformatf("out_st%0d", s.exp.st), 32'(o), 32'(s.exp));
         check($sformatf("count_st%0d", s.exp.st), (d == 0) ? cnt_a : cnt_b, s.cnt);
         @(posedge clk);
         #1;
      end
   endtask

   // Two reset cycles with mem_ready high; strobes must stay low throughout.
   task automatic do_reset(input int d);
      out_t o;
      set_rst(d, 1'b1);
      drive(d, 1'b1, 7'($urandom));
      @(negedge clk);
      o = (d == 0) ? obs_a : obs_b;
      check("rst_strobes_c0", strobes(o), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      o = (d == 0) ? obs_a : obs_b;
      check("rst_strobes_c1", strobes(o), 32'd0);
      check("rst_state", 32'(o.st), 32'(ST_F));
      check("rst_illegal", 32'(o.illegal), 32'd0);
      check("rst_count", (d == 0) ? cnt_a : cnt_b, 32'd0);
      @(posedge clk);
      #1;
      set_rst(d, 1'b0);
      exp_cnt = 32'd0;
   endtask

   logic [6:0] legal_ops [6];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_cnt  = 32'd0;
      legal_ops = '{OP_LD, OP_SD, OP_R, OP_IMM, OP_BEQ, OP_JAL};
      rst_a = 1'b1;
      rst_b = 1'b1;
      drive(0, 1'b0, 7'd0);
      drive(1, 1'b0, 7'd0);

      // Instance A: all opcodes enabled, 32-bit count.
      do_reset(0);
      push_instr(OP_R, 0, 0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      run_sb(0);
      check("r_count", cnt_a, 32'd1);
      push_instr(OP_LD, 3, 2, 1'b1, 1'b1, 32'hFFFF_FFFF);
      run_sb(0);
      push_instr(OP_SD, 0, 0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      push_instr(OP_BEQ, 0, 0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      run_sb(0);
      check("sd_beq_count", cnt_a, 32'd4);
      push_instr(OP_IMM, 1, 0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      push_instr(OP_JAL, 0, 0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      run_sb(0);
      for (int i = 0; i < 20; i++) begin
         push_instr(legal_ops[$urandom_range(0, 5)], int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), 1'b1, 1'b1, 32'hFFFF_FFFF);
      end
      run_sb(0);
      check("mix_count", cnt_a, exp_cnt);

      // Reset while an ld waits in MRD: abandoned, nothing written back.
      push_step(ST_F, 1'b1, 7'($urandom), 1'b0);
      push_step(ST_D, 1'b0, OP_LD, 1'b0);
      push_step(ST_MA, 1'b0, 7'($urandom), 1'b0);
      push_step(ST_MRD, 1'b0, 7'($urandom), 1'b0);
      run_sb(0);
      do_reset(0);
      push_instr(OP_BEQ, 0, 0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      run_sb(0);
      check("post_rst_count", cnt_a, 32'd1);

      // Undefined opcode traps A.
      push_instr(7'b1111111, 0, 0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      run_sb(0);
      do_reset(0);
      rst_a = 1'b1;

      // Instance B: OP-IMM and JAL disabled, 4-bit counter wraps after 16 retires.
      do_reset(1);
      for (int i = 0; i < 16; i++) begin
         push_instr(OP_R, int'($urandom_range(0, 1)), 0, 1'b0, 1'b0, 32'h0000_000F);
      end
      run_sb(1);
      check("wrap_count", cnt_b, 32'd0);
      push_instr(OP_BEQ, 0, 0, 1'b0, 1'b0, 32'h0000_000F);
      push_instr(OP_IMM, 0, 0, 1'b0, 1'b0, 32'h0000_000F);
      run_sb(1);
      check("trap_count", cnt_b, 32'd1);
      do_reset(1);
      push_instr(OP_JAL, 0, 0, 1'b0, 1'b0, 32'h0000_000F);
      run_sb(1);
      do_reset(1);
      push_instr(OP_SD, 0, 1, 1'b0, 1'b0, 32'h0000_000F);
      run_sb(1);
      check("b_final_count", cnt_b, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
